// File: rtl/forward_ctrl.sv
// forward_ctrl: ALU operand forwarding and load-use stall control for a 5-stage pipeline.
//
// Keeps a shadow copy of the register fields flowing through ID/EX, EX/MEM and MEM/WB.
// It produces registered forwarding selects that are valid for the whole EX cycle of the
// instruction they belong to.
//
// Ports:
//   clk          in   pipeline clock, rising edge
//   reset        in   asynchronous active-high reset, clears all tracking
//   id_rs/id_rt  in   [4:0] source registers of the instruction in ID
//   id_rd        in   [4:0] destination register of the ID instruction (after RegDst)
//   id_regwrite  in   ID instruction writes the register file
//   id_memread   in   ID instruction is a load
//   forward_a/b  out  [1:0] operand mux select: 00 regfile, 01 EX/MEM result, 10 MEM/WB data
//   stall        out  load-use stall request to PC, IF/ID and ID/EX
//
// Build option:
//   LOAD_USE_STALL_EN  defined: detect load-use hazards and stall one cycle.
//                      undefined: stall tied low, a load-use consumer gets code 01.

module forward_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       id_regwrite,
  input  logic       id_memread,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b,
  output logic       stall
);

  localparam logic [1:0] FwdReg = 2'b00;
  localparam logic [1:0] FwdMem = 2'b01;  // EX/MEM ALU result
  localparam logic [1:0] FwdWb  = 2'b10;  // MEM/WB write data

  // ID/EX shadow
  logic [4:0] r_ex_rs;
  logic [4:0] r_ex_rt;
  logic [4:0] r_ex_rd;
  logic       r_ex_regwrite;
  logic       r_ex_memread;
  // EX/MEM shadow
  logic [4:0] r_mem_rd;
  logic       r_mem_regwrite;
  // MEM/WB shadow
  logic [4:0] r_wb_rd;
  logic       r_wb_regwrite;

  logic [1:0] r_forward_a;
  logic [1:0] r_forward_b;

  logic [1:0] w_fwd_a_d;
  logic [1:0] w_fwd_b_d;
  logic       w_stall;
  logic       w_unused;

  // The instruction currently in ID/EX will be in EX/MEM when the ID instruction reaches EX,
  // and the one in EX/MEM will be in MEM/WB. Checking EX first gives the most recent producer
  // priority. Anything already in MEM/WB has written the register file by then.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] ex_rd, input logic ex_we,
                                         input logic [4:0] mem_rd, input logic mem_we);
    logic [1:0] sel;
    sel = FwdReg;
    if (ex_we && (ex_rd != 5'd0) && (ex_rd == src)) begin
      sel = FwdMem;
    end else if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) begin
      sel = FwdWb;
    end
    return sel;
  endfunction

  always_comb begin
    w_fwd_a_d = fwd_sel(id_rs, r_ex_rd, r_ex_regwrite, r_mem_rd, r_mem_regwrite);
    w_fwd_b_d = fwd_sel(id_rt, r_ex_rd, r_ex_regwrite, r_mem_rd, r_mem_regwrite);
  end

`ifdef LOAD_USE_STALL_EN
  // A load in EX cannot forward its data to the next instruction in time; hold ID for one
  // cycle so the load reaches MEM/WB and the consumer picks it up via code 10.
  assign w_stall = r_ex_memread && (r_ex_rd != 5'd0) &&
                   ((r_ex_rd == id_rs) || (r_ex_rd == id_rt));
  // Source fields and MEM/WB are tracked for visibility only; nothing reads them.
  assign w_unused = ^{r_ex_rs, r_ex_rt, r_wb_rd, r_wb_regwrite};
`else
  assign w_stall  = 1'b0;
  assign w_unused = ^{r_ex_rs, r_ex_rt, r_wb_rd, r_wb_regwrite, r_ex_memread};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_rs        <= 5'd0;
      r_ex_rt        <= 5'd0;
      r_ex_rd        <= 5'd0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_mem_rd       <= 5'd0;
      r_mem_regwrite <= 1'b0;
      r_wb_rd        <= 5'd0;
      r_wb_regwrite  <= 1'b0;
      r_forward_a    <= FwdReg;
      r_forward_b    <= FwdReg;
    end else begin
      r_mem_rd       <= r_ex_rd;
      r_mem_regwrite <= r_ex_regwrite;
      r_wb_rd        <= r_mem_rd;
      r_wb_regwrite  <= r_mem_regwrite;
      if (w_stall) begin
        // Bubble: no destination, no write, no load, no forwarding.
        r_ex_rs       <= 5'd0;
        r_ex_rt       <= 5'd0;
        r_ex_rd       <= 5'd0;
        r_ex_regwrite <= 1'b0;
        r_ex_memread  <= 1'b0;
        r_forward_a   <= FwdReg;
        r_forward_b   <= FwdReg;
      end else begin
        r_ex_rs       <= id_rs;
        r_ex_rt       <= id_rt;
        r_ex_rd       <= id_rd;
        r_ex_regwrite <= id_regwrite;
        r_ex_memread  <= id_memread;
        r_forward_a   <= w_fwd_a_d;
        r_forward_b   <= w_fwd_b_d;
      end
    end
  end

  assign forward_a = r_forward_a;
  assign forward_b = r_forward_b;
  assign stall     = w_stall;

endmodule

// File: tb/tb_forward_ctrl.sv
// Self-checking bench for forward_ctrl: directed hazard scenarios plus randomized
// instruction streams compared with an instruction-history reference model.

`timescale 1ns/1ps

module tb_forward_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic [1:0] forward_a;
  logic [1:0] forward_b;
  logic       stall;

  int total;
  int bad;

  forward_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .id_regwrite(id_regwrite),
    .id_memread (id_memread),
    .forward_a  (forward_a),
    .forward_b  (forward_b),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LOAD_USE_STALL_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  // Reference model: list of instructions that have entered EX, most recent first.
  typedef struct packed {
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } ins_t;

  ins_t       hist[$];
  logic [1:0] exp_fa;
  logic [1:0] exp_fb;

  // Producer one ahead -> 01, two ahead -> 10, older or none -> 00.
  function automatic logic [1:0] model_fwd(input logic [4:0] r);
    for (int i = 0; i < 2; i++) begin
      if (i < hist.size()) begin
        if (hist[i].rw && hist[i].rd != 5'd0 && hist[i].rd == r) begin
          return (i == 0) ? 2'b01 : 2'b10;
        end
      end
    end
    return 2'b00;
  endfunction

  function automatic logic model_stall();
    if (!StallEn || hist.size() == 0) return 1'b0;
    return hist[0].mr && hist[0].rd != 5'd0 && (hist[0].rd == id_rs || hist[0].rd == id_rt);
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic rw, input logic mr);
    id_rs       = rs;
    id_rt       = rt;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  // Clock once; model predicts what enters EX and its forwarding selects.
  task automatic tick();
    ins_t e;
    if (model_stall()) begin
      e      = '0;
      exp_fa = 2'b00;
      exp_fb = 2'b00;
    end else begin
      e.rd   = id_rd;
      e.rw   = id_regwrite;
      e.mr   = id_memread;
      exp_fa = model_fwd(id_rs);
      exp_fb = model_fwd(id_rt);
    end
    @(posedge clk);
    #1;
    hist.push_front(e);
    if (hist.size() > 2) void'(hist.pop_back());
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(5'd3, 5'd4, 5'd5, 1'b1, 1'b1);
    #12;
    total++;
    if (forward_a !== 2'b00) begin
      bad++; $display("FAIL reset_fa: got %b want 00", forward_a);
    end
    total++;
    if (forward_b !== 2'b00) begin
      bad++; $display("FAIL reset_fb: got %b want 00", forward_b);
    end
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL reset_stall: got %b want 0", stall);
    end
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    reset = 1'b0;
    hist.delete();
    tick();
    total++;
    if (forward_a !== 2'b00 || forward_b !== 2'b00) begin
      bad++; $display("FAIL reset_first_edge: got %b/%b want 00/00", forward_a, forward_b);
    end
  endtask

  task automatic test_ex_fwd();
    drive(5'd1, 5'd2, 5'd3, 1'b1, 1'b0);   // add $3
    tick();
    drive(5'd3, 5'd4, 5'd6, 1'b1, 1'b0);   // sub rs=$3 rt=$4
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL ex_fwd_stall: got %b want 0", stall);
    end
    tick();
    total++;
    if (forward_a !== 2'b01) begin
      bad++; $display("FAIL ex_fwd_a: got %b want 01", forward_a);
    end
    total++;
    if (forward_b !== 2'b00) begin
      bad++; $display("FAIL ex_fwd_b: got %b want 00", forward_b);
    end
  endtask

  task automatic test_mem_fwd();
    drive(5'd13, 5'd14, 5'd5, 1'b1, 1'b0);  // producer $5
    tick();
    drive(5'd11, 5'd12, 5'd10, 1'b1, 1'b0); // unrelated
    tick();
    drive(5'd1, 5'd5, 5'd15, 1'b1, 1'b0);   // consumer rt=$5
    tick();
    total++;
    if (forward_b !== 2'b10) begin
      bad++; $display("FAIL mem_fwd_b: got %b want 10", forward_b);
    end
    total++;
    if (forward_a !== 2'b00) begin
      bad++; $display("FAIL mem_fwd_a: got %b want 00", forward_a);
    end
  endtask

  task automatic test_priority();
    drive(5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
    tick();
    drive(5'd2, 5'd1, 5'd7, 1'b1, 1'b0);
    tick();
    drive(5'd7, 5'd7, 5'd0, 1'b0, 1'b0);
    tick();
    total++;
    if (forward_a !== 2'b01 || forward_b !== 2'b01) begin
      bad++; $display("FAIL priority: got %b/%b want 01/01", forward_a, forward_b);
    end
  endtask

  task automatic test_r0();
    drive(5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    total++;
    if (forward_a !== 2'b00 || forward_b !== 2'b00) begin
      bad++; $display("FAIL r0_no_fwd: got %b/%b want 00/00", forward_a, forward_b);
    end
  endtask

  task automatic test_load_use();
    drive(5'd1, 5'd2, 5'd8, 1'b1, 1'b1);   // lw $8
    tick();
    drive(5'd8, 5'd9, 5'd11, 1'b1, 1'b0);  // consumer rs=$8
    #1;
    total++;
    if (stall !== StallEn) begin
      bad++; $display("FAIL load_use_stall: got %b want %b", stall, StallEn);
    end
    tick();
    if (StallEn) begin
      total++;
      if (forward_a !== 2'b00 || forward_b !== 2'b00) begin
        bad++; $display("FAIL load_use_bubble: got %b/%b want 00/00", forward_a, forward_b);
      end
      total++;
      if (stall !== 1'b0) begin
        bad++; $display("FAIL load_use_one_cycle: got %b want 0", stall);
      end
      tick();
      total++;
      if (forward_a !== 2'b10) begin
        bad++; $display("FAIL load_use_fwd: got %b want 10", forward_a);
      end
    end else begin
      total++;
      if (forward_a !== 2'b01) begin
        bad++; $display("FAIL load_use_fwd: got %b want 01", forward_a);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(5'd1, 5'd2, 5'd9, 1'b1, 1'b1);   // lw $9
    tick();
    drive(5'd9, 5'd3, 5'd12, 1'b1, 1'b0);  // consumer rs=$9
    #1;
    total++;
    if (stall !== StallEn) begin
      bad++; $display("FAIL mid_pre_stall: got %b want %b", stall, StallEn);
    end
    reset = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0 || forward_a !== 2'b00 || forward_b !== 2'b00) begin
      bad++; $display("FAIL mid_async_clear: got %b/%b/%b want 0/00/00",
                      stall, forward_a, forward_b);
    end
    #2;
    reset = 1'b0;
    hist.delete();
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL mid_post_stall: got %b want 0", stall);
    end
    tick();
    total++;
    if (forward_a !== 2'b00) begin
      bad++; $display("FAIL mid_no_stale: got %b want 00", forward_a);
    end
    drive(5'd12, 5'd0, 5'd0, 1'b0, 1'b0);  // depends on the post-reset consumer
    tick();
    total++;
    if (forward_a !== 2'b01) begin
      bad++; $display("FAIL mid_reload: got %b want 01", forward_a);
    end
  endtask

  task automatic test_random();
    logic       mr;
    logic [1:0] want_s;
    for (int n = 0; n < 400; n++) begin
      mr = ($urandom_range(0, 3) == 0);
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            mr | 1'($urandom_range(0, 1)), mr);
      #1;
      want_s = {1'b0, model_stall()};
      total++;
      if (stall !== want_s[0]) begin
        bad++; $display("FAIL rnd_stall[%0d]: got %b want %b", n, stall, want_s[0]);
      end
      tick();
      total++;
      if (forward_a !== exp_fa) begin
        bad++; $display("FAIL rnd_fa[%0d]: got %b want %b", n, forward_a, exp_fa);
      end
      total++;
      if (forward_b !== exp_fb) begin
        bad++; $display("FAIL rnd_fb[%0d]: got %b want %b", n, forward_b, exp_fb);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_ex_fwd();
    test_mem_fwd();
    test_priority();
    test_r0();
    test_load_use();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
